// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and constants for the bit-serial subtractor.
//               Provides the controller state encoding and the default
//               operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } sub_state_e;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_sub_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_sub_cell
// Description : 1-bit full subtractor, purely combinational.
//               Computes x - y - bi, producing difference d and borrow bo.
// Ports       : x  (in)  minuend bit
//               y  (in)  subtrahend bit
//               bi (in)  borrow-in
//               d  (out) difference bit
//               bo (out) borrow-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // A borrow is needed whenever the bits to subtract outweigh x.
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule : full_sub_cell
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial WIDTH-bit subtractor controller. Captures a, b and
//               bin on the accept edge, then walks a single full-subtractor
//               cell LSB-first over WIDTH cycles and presents the registered
//               difference and borrow-out with a one-cycle done pulse.
// Ports       : clk   (in)  clock, rising edge
//               rst   (in)  asynchronous active-high reset
//               start (in)  request, sampled only while idle
//               a     (in)  minuend   [WIDTH-1:0]
//               b     (in)  subtrahend[WIDTH-1:0]
//               bin   (in)  borrow-in
//               busy  (out) high while shifting
//               done  (out) one-cycle result-valid pulse
//               diff  (out) a-b-bin mod 2^WIDTH, held until next done
//               bout  (out) borrow-out, 1 iff a < b+bin
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int               C_CNT_W    = $clog2(WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);

  sub_state_e         r_state;
  sub_state_e         w_next_state;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_d_sr;
  logic               r_brw;
  logic [C_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic               w_d;
  logic               w_bo;
  logic               w_last;

  full_sub_cell u_cell (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .bi (r_brw),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last = (r_cnt == C_CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status decode; busy/done depend only on the state
  // register so they carry no combinational path from the inputs.
  always_comb begin
    w_next_state = S_IDLE;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = start ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        w_busy       = 1'b1;
        w_next_state = w_last ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand shift registers, borrow chain, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_d_sr <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_d_sr <= '0;
            r_brw  <= bin;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          // Difference bits enter at the MSB so the LSB lands at bit 0
          // after WIDTH shifts.
          r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
          r_brw  <= w_bo;
          if (w_last) begin
            r_diff <= {w_d, r_d_sr[WIDTH-1:1]};
            r_bout <= w_bo;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = w_busy;
  assign done = w_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule : serial_sub_ctrl
`default_nettype wire
